// File: rtl/latency_memory_pkg.sv
// Shared types and default sizes for the latency memory.
// Imported by the interface, arbiter and top.
package latency_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    localparam int DEF_WORD_W     = 16;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DEPTH      = 256;
    localparam int DEF_LATENCY    = 2;
    localparam int DEF_LINE_WORDS = 4;

endpackage

// File: rtl/latency_memory_if.sv
// Request/response bundle for one memory port.
// The requester uses master and the memory uses slave.
interface latency_memory_if
    import latency_mem_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req;
    logic              we;
    logic              burst;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              rvalid;
    logic              ack;

    modport master (
        output req, we, burst, addr, wdata,
        input  rdata, rvalid, ack
    );

    modport slave (
        input  req, we, burst, addr, wdata,
        output rdata, rvalid, ack
    );
endinterface

// File: rtl/latency_memory_arbiter.sv
// Two-way round-robin grant between the i and d ports.
// prio_q names the port that wins the next conflict.
module mem_arbiter
    import latency_mem_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  req_i,
    input  logic  req_d,
    input  logic  advance,
    output port_t grant,
    output logic  valid
);
    port_t prio_q;

    always_comb begin
        valid = req_i | req_d;
        grant = PORT_D;
        if (req_i && req_d)
            grant = prio_q;
        else if (req_i)
            grant = PORT_I;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            prio_q <= PORT_D;
        else if (advance)
            prio_q <= (grant == PORT_I) ? PORT_D : PORT_I;
    end
endmodule

// File: rtl/latency_memory.sv
// Dual-port (i/d) register-array memory with fixed access latency
// and optional line bursts; one transaction in flight at a time.
module latency_memory
    import latency_mem_pkg::*;
#(
    parameter int    WORD_W     = DEF_WORD_W,
    parameter int    ADDR_W     = DEF_ADDR_W,
    parameter int    DEPTH      = DEF_DEPTH,
    parameter int    LATENCY    = DEF_LATENCY,
    parameter int    LINE_WORDS = DEF_LINE_WORDS,
    parameter string INIT_FILE  = ""
)
(
    input logic             clk,
    input logic             reset_n,
    latency_memory_if.slave i_bus,
    latency_memory_if.slave d_bus
);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(LATENCY + LINE_WORDS + 1);
    localparam int WAIT_END = (LATENCY > 1) ? LATENCY - 2 : 0;

    logic [WORD_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_t             port_q;
    logic              we_q, burst_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;

    logic              i_rvalid_q, i_ack_q, d_rvalid_q, d_ack_q;
    logic [WORD_W-1:0] i_rdata_q, d_rdata_q;

    port_t             grant;
    logic              gnt_valid;
    logic              accept, do_beat, last_beat;
    logic [IDX_W-1:0]  line_base, beat_idx;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^{i_bus.addr[ADDR_W-1:IDX_W],
                              d_bus.addr[ADDR_W-1:IDX_W]};

    mem_arbiter u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (i_bus.req),
        .req_d   (d_bus.req),
        .advance (accept),
        .grant   (grant),
        .valid   (gnt_valid)
    );

    // Bursts start at the line-aligned base and never wrap.
    assign line_base = idx_q & ~IDX_W'(LINE_WORDS - 1);
    assign beat_idx  = (we_q || !burst_q) ? idx_q
                                          : line_base + IDX_W'(cnt_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        do_beat   = 1'b0;
        last_beat = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = (LATENCY == 1) ? S_XFER : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(WAIT_END)) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_XFER: begin
                do_beat   = 1'b1;
                last_beat = we_q || !burst_q ||
                            (cnt_q == CNT_W'(LINE_WORDS - 1));
                if (last_beat)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            port_q     <= PORT_D;
            we_q       <= 1'b0;
            burst_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            i_rvalid_q <= 1'b0;
            i_ack_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_ack_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_rvalid_q <= 1'b0;
            i_ack_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_ack_q    <= 1'b0;
            if (accept) begin
                port_q <= grant;
                if (grant == PORT_D) begin
                    we_q    <= d_bus.we;
                    burst_q <= d_bus.burst;
                    idx_q   <= d_bus.addr[IDX_W-1:0];
                    wdata_q <= d_bus.wdata;
                end else begin
                    we_q    <= i_bus.we;
                    burst_q <= i_bus.burst;
                    idx_q   <= i_bus.addr[IDX_W-1:0];
                    wdata_q <= i_bus.wdata;
                end
            end
            if (do_beat) begin
                if (port_q == PORT_I) begin
                    i_ack_q    <= last_beat;
                    i_rvalid_q <= !we_q;
                    if (!we_q)
                        i_rdata_q <= mem[beat_idx];
                end else begin
                    d_ack_q    <= last_beat;
                    d_rvalid_q <= !we_q;
                    if (!we_q)
                        d_rdata_q <= mem[beat_idx];
                end
            end
        end
    end

    // Array has no reset; a write is dropped if reset is asserted.
    always_ff @(posedge clk) begin
        if (reset_n && do_beat && we_q)
            mem[beat_idx] <= wdata_q;
    end

    assign i_bus.rdata  = i_rdata_q;
    assign i_bus.rvalid = i_rvalid_q;
    assign i_bus.ack    = i_ack_q;
    assign d_bus.rdata  = d_rdata_q;
    assign d_bus.rvalid = d_rvalid_q;
    assign d_bus.ack    = d_ack_q;
endmodule

// File: tb/tb_latency_memory.sv
// Self-checking bench for latency_memory: directed table, corner
// sequences and random traffic against a cycle-level reference model.
module tb_latency_memory;
    localparam int L  = 2;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    latency_memory_if #(.WORD_W(16), .ADDR_W(16)) i_if ();
    latency_memory_if #(.WORD_W(16), .ADDR_W(16)) d_if ();
    latency_memory_if #(.WORD_W(16), .ADDR_W(16)) l1_i ();
    latency_memory_if #(.WORD_W(16), .ADDR_W(16)) l1_d ();
    latency_memory_if #(.WORD_W(16), .ADDR_W(16)) l5_i ();
    latency_memory_if #(.WORD_W(16), .ADDR_W(16)) l5_d ();

    latency_memory #(.LATENCY(L), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset_n(reset_n), .i_bus(i_if), .d_bus(d_if)
    );
    latency_memory #(.LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .i_bus(l1_i), .d_bus(l1_d)
    );
    latency_memory #(.LATENCY(5)) dut_l5 (
        .clk(clk), .reset_n(reset_n), .i_bus(l5_i), .d_bus(l5_d)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        bit          burst;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_first;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] ref_mem [256];
    logic [15:0] last_rd [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check6(bit irv, bit iack, bit drv, bit dack);
        chk("i_rvalid", 32'(i_if.rvalid), 32'(irv));
        chk("i_ack", 32'(i_if.ack), 32'(iack));
        chk("d_rvalid", 32'(d_if.rvalid), 32'(drv));
        chk("d_ack", 32'(d_if.ack), 32'(dack));
        chk("i_rdata", 32'(i_if.rdata), 32'(last_rd[0]));
        chk("d_rdata", 32'(d_if.rdata), 32'(last_rd[1]));
    endtask

    task automatic drive(bit is_d, bit req, bit we, bit burst,
                         logic [15:0] addr, logic [15:0] wdata);
        if (is_d) begin
            d_if.req = req; d_if.we = we; d_if.burst = burst;
            d_if.addr = addr; d_if.wdata = wdata;
        end else begin
            i_if.req = req; i_if.we = we; i_if.burst = burst;
            i_if.addr = addr; i_if.wdata = wdata;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        last_rd[0] = '0;
        last_rd[1] = '0;
        check6(0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    // One transaction on an idle DUT, checked cycle by cycle.
    task automatic do_txn(bit is_d, bit we, bit burst, logic [15:0] addr,
                          logic [15:0] wdata, bit drop,
                          output logic [15:0] got);
        int          n;
        logic [7:0]  idx, base;
        logic [15:0] exp_beat [4];
        bit          rv, ak;
        idx  = addr[7:0];
        n    = (we || !burst) ? 1 : LW;
        base = (we || !burst) ? idx : (idx & 8'hFC);
        for (int k = 0; k < 4; k++)
            exp_beat[k] = ref_mem[base + 8'(k)];
        got = '0;
        drive(is_d, 1'b1, we, burst, addr, wdata);
        tick();
        drive(is_d, !drop, 1'($urandom), 1'($urandom),
              16'($urandom), 16'($urandom));
        for (int t = 1; t <= L + n - 1; t++) begin
            if (t == L && we)
                ref_mem[idx] = wdata;
            if (!we && t >= L)
                last_rd[is_d] = exp_beat[t-L];
            tick();
            rv = !we && (t >= L);
            ak = (t == L + n - 1);
            check6(!is_d && rv, !is_d && ak, is_d && rv, is_d && ak);
            if (t == L)
                got = is_d ? d_if.rdata : i_if.rdata;
        end
        drive(is_d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic lat_drive(int w, bit req, bit we, logic [15:0] addr,
                             logic [15:0] wdata);
        if (w == 0) begin
            l1_d.req = req; l1_d.we = we; l1_d.addr = addr; l1_d.wdata = wdata;
        end else begin
            l5_d.req = req; l5_d.we = we; l5_d.addr = addr; l5_d.wdata = wdata;
        end
    endtask

    function automatic logic lat_ack(int w);
        return (w == 0) ? l1_d.ack : l5_d.ack;
    endfunction

    task automatic lat_test(int w, int lat);
        int          c;
        logic [15:0] rd;
        lat_drive(w, 1'b1, 1'b1, 16'h01FF, 16'hC0DE);
        tick();
        c = 0;
        do begin tick(); c++; end while (!lat_ack(w) && c < 20);
        lat_drive(w, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("lat_write_ack", 32'(c), 32'(lat));
        lat_drive(w, 1'b1, 1'b0, 16'h00FF, 16'h0);
        tick();
        c = 0;
        do begin tick(); c++; end while (!lat_ack(w) && c < 20);
        lat_drive(w, 1'b0, 1'b0, 16'h0, 16'h0);
        rd = (w == 0) ? l1_d.rdata : l5_d.rdata;
        chk("lat_read_cycles", 32'(c + 1), 32'(lat + 1));
        chk("lat_alias_data", 32'(rd), 32'h0000C0DE);
    endtask

    vec_t        vecs [10];
    logic [15:0] got;
    logic [7:0]  b;

    initial begin
        vecs[0] = '{1, 1, 0, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1] = '{1, 0, 0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[2] = '{0, 0, 1, 16'h0025, 16'h0000, 16'h24DB};
        vecs[3] = '{1, 0, 0, 16'h01FF, 16'h0000, 16'hFF00};
        vecs[4] = '{0, 1, 0, 16'h0030, 16'h1234, 16'h0000};
        vecs[5] = '{0, 0, 0, 16'h8030, 16'h0000, 16'h1234};
        vecs[6] = '{1, 0, 1, 16'h00FE, 16'h0000, 16'hFC03};
        vecs[7] = '{1, 1, 1, 16'h0040, 16'h5555, 16'h0000};
        vecs[8] = '{0, 0, 0, 16'h0040, 16'h0000, 16'h5555};
        vecs[9] = '{1, 0, 0, 16'hFF00, 16'h0000, 16'h00FF};

        drive(0, 0, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        l1_i.req = 0; l1_i.we = 0; l1_i.burst = 0; l1_i.addr = '0; l1_i.wdata = '0;
        l5_i.req = 0; l5_i.we = 0; l5_i.burst = 0; l5_i.addr = '0; l5_i.wdata = '0;
        l1_d.burst = 0; l5_d.burst = 0;
        lat_drive(0, 0, 0, 16'h0, 16'h0);
        lat_drive(1, 0, 0, 16'h0, 16'h0);
        do_reset();

        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            do_txn(i[0], 1'b1, 1'b0, 16'(i), {b, ~b}, 1'b0, got);
        end

        foreach (vecs[v]) begin
            do_txn(vecs[v].is_d, vecs[v].we, vecs[v].burst, vecs[v].addr,
                   vecs[v].wdata, 1'b0, got);
            if (!vecs[v].we)
                chk($sformatf("vec%0d_first", v), 32'(got),
                    32'(vecs[v].exp_first));
        end

        do_txn(0, 0, 1, 16'h0025, 16'h0, 1'b1, got);
        chk("drop_burst_first", 32'(got), 32'(ref_mem[8'h24]));

        for (int r = 0; r < 80; r++)
            do_txn(1'($urandom), ($urandom_range(0, 3) == 0),
                   1'($urandom), 16'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0), got);

        // Simultaneous requests after reset: d first, then i re-granted.
        do_reset();
        drive(1, 1, 0, 0, 16'h0010, 16'h0);
        drive(0, 1, 0, 0, 16'h0040, 16'h0);
        tick();
        for (int t = 1; t <= 2 * L + 1; t++) begin
            if (t == L)
                last_rd[1] = ref_mem[8'h10];
            if (t == 2 * L + 1)
                last_rd[0] = ref_mem[8'h40];
            tick();
            check6(t == 2 * L + 1, t == 2 * L + 1, t == L, t == L);
        end
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        drive(0, 0, 0, 0, 16'h0, 16'h0);

        // Reset during WAIT of a write must leave the old word in place.
        do_txn(1, 1, 0, 16'h0030, 16'h1234, 1'b0, got);
        drive(1, 1, 1, 0, 16'h0030, 16'h9999);
        tick();
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        do_reset();
        tick();
        check6(0, 0, 0, 0);
        do_txn(1, 0, 0, 16'h0030, 16'h0, 1'b0, got);
        chk("reset_abort_write", 32'(got), 32'h00001234);

        lat_test(0, 1);
        lat_test(1, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
